fifo_wptr_full_ctrl: RTL and testbench

- Write-domain pointer and flag controller for the async FIFO.
- Owns the binary/gray write pointer and exports the registered gray pointer to the read domain.
- Synchronizes the read domain's gray pointer, decodes it to binary and derives full, almost_full and fill level.
- Sits between the write-side user interface, the dual-port RAM write address and the cross-domain pointer paths.

---
 rtl/fifo_wptr_full_ctrl.sv | 96 +++++++++
 tb/tb_fifo_wptr_full_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-side pointer/flag controller for the async FIFO.
// Ports: clk, rst_n (async low); wr_en in; rptr_gray_async in (read gray ptr);
//   wr_accept, waddr, wptr_gray, full, almost_full, wr_level, overflow out.
// Optional: define FIFO_OVERFLOW_FLAG_EN to build the sticky overflow flop.
module fifo_wptr_full_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;

    // Full when the write gray pointer equals the read gray pointer
    // with its two MSBs inverted.
    localparam logic [PW-1:0] TOPMASK = PW'(3) << (PW - 2);
    localparam logic [PW-1:0] AFT     = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_next;
    logic [PW-1:0] sync_q [SYNC_STAGES];

    assign wr_accept  = wr_en & ~full;
    assign waddr      = wbin[ADDR_WIDTH-1:0];
    assign wbin_next  = wbin + PW'(wr_accept);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign rq         = sync_q[SYNC_STAGES-1];
    assign level_next = wbin_next - rbin_s;

    // Gray to binary: bit i is the XOR of gray bits i..MSB.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_s[i] = ^(rq >> i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Flags use next-state pointers so the filling write blocks the
    // very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == (rq ^ TOPMASK));
            almost_full <= (level_next >= AFT);
            wr_level    <= level_next;
        end
    end

`ifdef FIFO_OVERFLOW_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en & full) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Bench for fifo_wptr_full_ctrl: vector table + expected-value queue.
// Second instance with AFULL_THRESH=16 checks almost_full/full coincidence.
module tb_fifo_wptr_full_ctrl;

`ifdef FIFO_OVERFLOW_FLAG_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [4:0] rptr_gray_async;
    logic       wr_accept, full, almost_full, overflow;
    logic [3:0] waddr;
    logic [4:0] wptr_gray, wr_level;
    logic       wr_accept16, full16, almost_full16, overflow16;
    logic [3:0] waddr16;
    logic [4:0] wptr_gray16, wr_level16;

    fifo_wptr_full_ctrl #(
        .ADDR_WIDTH(4), .SYNC_STAGES(2), .AFULL_THRESH(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
        .rptr_gray_async(rptr_gray_async),
        .wr_accept(wr_accept), .waddr(waddr), .wptr_gray(wptr_gray),
        .full(full), .almost_full(almost_full), .wr_level(wr_level),
        .overflow(overflow)
    );

    fifo_wptr_full_ctrl #(
        .ADDR_WIDTH(4), .SYNC_STAGES(2), .AFULL_THRESH(16)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
        .rptr_gray_async(rptr_gray_async),
        .wr_accept(wr_accept16), .waddr(waddr16), .wptr_gray(wptr_gray16),
        .full(full16), .almost_full(almost_full16), .wr_level(wr_level16),
        .overflow(overflow16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [4:0] rbin;
        logic       acc;
        logic [4:0] bin;
        logic       full;
        logic       afull;
        logic       afull16;
        logic [4:0] level;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    vec_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n1;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic vec_t mk(input logic wr, input int rbin,
        input logic acc, input int bin, input logic f, input logic af,
        input logic af16, input int lvl, input logic ov);
        vec_t v;
        v.wr = wr;        v.rbin = 5'(rbin);  v.acc = acc;
        v.bin = 5'(bin);  v.full = f;         v.afull = af;
        v.afull16 = af16; v.level = 5'(lvl);  v.ovf = ov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        wr_en = v.wr;
        rptr_gray_async = g(v.rbin);
        #1;
        chk("wr_accept", 32'(wr_accept), 32'(v.acc));
        sbq.push_back(v);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wptr_gray"}, 32'(wptr_gray), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_afull"}, 32'(almost_full), 32'd0);
        chk({tag, "_level"}, 32'(wr_level), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_afull16"}, 32'(almost_full16), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("wptr_gray", 32'(wptr_gray), 32'(g(e.bin)));
            chk("waddr", 32'(waddr), 32'(e.bin[3:0]));
            chk("full", 32'(full), 32'(e.full));
            chk("almost_full", 32'(almost_full), 32'(e.afull));
            chk("wr_level", 32'(wr_level), 32'(e.level));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("full16", 32'(full16), 32'(e.full));
            chk("almost_full16", 32'(almost_full16), 32'(e.afull16));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill from empty with read pointer parked at 0.
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, 1, i + 1, i == 15, (i + 1) >= 12,
                             i == 15, i + 1, 0));
        // Writes while full are dropped.
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(1, 0, 0, 16, 1, 1, 1, 16, OVF));
        // Read pointer moves to 1: flags follow three edges later.
        for (int j = 0; j < 3; j++)
            tbl.push_back(mk(0, 1, 0, 16, j < 2, 1, j < 2,
                             (j < 2) ? 16 : 15, OVF));
        tbl.push_back(mk(0, 1, 0, 16, 0, 1, 0, 15, OVF));
        // One write refills: full on the same edge.
        tbl.push_back(mk(1, 1, 1, 17, 1, 1, 1, 16, OVF));
        n1 = tbl.size();
        // Wrap: read pointer trails the writes by 4.
        for (int k = 0; k < 40; k++)
            tbl.push_back(mk(1, (k >= 4) ? (k - 4) : 0, 1, (k + 1) % 32,
                             0, 0, 0, (k <= 5) ? (k + 1) : 7, 0));

        wr_en = 1'b0;
        rptr_gray_async = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("rst0");
        rst_n = 1'b1;
        #1;
        chk_zero("rel0");

        for (int i = 0; i < n1; i++) apply(tbl[i]);

        // Mid-cycle reset with writes requested.
        @(negedge clk);
        wr_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
        rptr_gray_async = '0;
        #1;
        chk_zero("relmid");

        for (int i = n1; i < tbl.size(); i++) apply(tbl[i]);

        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
